// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial PATTERN detector with match pulse and saturating hit count
// Optional SEQ_DET_CLEAR_EN adds a synchronous Clear input that empties window, fill state and count.
module seq_detector #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CW      = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Enable,
`ifdef SEQ_DET_CLEAR_EN
  input  logic          Clear,
`endif
  input  logic          Din,
  output logic          Match,
  output logic [CW-1:0] Count,
  output logic [N-1:0]  Shift
);

  localparam int FW = $clog2(N);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

  typedef enum logic {FILL, HUNT} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   fill_cnt, fill_nxt;
  logic [N-1:0]    shift_nxt;
  logic [N-1:0]    window;
  logic [CW-1:0]   count_nxt;
  logic            match_nxt;
  logic            hit;

  assign window = {Shift[N-2:0], Din};
  // A window only counts once N bits have arrived since reset (or since the last match without overlap).
  assign hit    = (window == PATTERN) && ((state == HUNT) || (fill_cnt == FILL_LAST));

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    shift_nxt = Shift;
    count_nxt = Count;
    match_nxt = 1'b0;

    if (Enable) begin
      shift_nxt = window;
      if (state == FILL) begin
        if (fill_cnt == FILL_LAST) begin
          state_nxt = HUNT;
          fill_nxt  = '0;
        end else begin
          fill_nxt  = fill_cnt + 1'b1;
        end
      end
      if (hit) begin
        match_nxt = 1'b1;
        count_nxt = (&Count) ? Count : Count + 1'b1;
        if (OVERLAP == 0) begin
          state_nxt = FILL;
          fill_nxt  = '0;
        end else begin
          state_nxt = HUNT;
        end
      end
    end

`ifdef SEQ_DET_CLEAR_EN
    if (Clear) begin
      state_nxt = FILL;
      fill_nxt  = '0;
      shift_nxt = '0;
      count_nxt = '0;
      match_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= FILL;
      fill_cnt <= '0;
      Shift    <= '0;
      Count    <= '0;
      Match    <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      Shift    <= shift_nxt;
      Count    <= count_nxt;
      Match    <= match_nxt;
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector across overlap and counter-width variants
// Honours SEQ_DET_CLEAR_EN when the design is built with it.
module tb_seq_detector;

  logic       Clock  = 1'b0;
  logic       Resetn = 1'b0;
  logic       Enable = 1'b0;
  logic       Din    = 1'b0;
`ifdef SEQ_DET_CLEAR_EN
  logic       Clear  = 1'b0;
`endif
  logic [2:0] match;
  logic [7:0] count0;
  logic [1:0] count1, count2;
  logic [3:0] shift0, shift1, shift2;

  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CW(8)) u0 (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
`ifdef SEQ_DET_CLEAR_EN
    .Clear(Clear),
`endif
    .Din(Din), .Match(match[0]), .Count(count0), .Shift(shift0));

  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CW(2)) u1 (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
`ifdef SEQ_DET_CLEAR_EN
    .Clear(Clear),
`endif
    .Din(Din), .Match(match[1]), .Count(count1), .Shift(shift1));

  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CW(2)) u2 (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
`ifdef SEQ_DET_CLEAR_EN
    .Clear(Clear),
`endif
    .Din(Din), .Match(match[2]), .Count(count2), .Shift(shift2));

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] m;
    logic [7:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] s2;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference: window is the last four bits as a number, valid counts bits eligible for a match.
  int   ovl[3]  = '{1, 0, 1};
  int   cmax[3] = '{255, 3, 3};
  int   win[3];
  int   valid[3];
  int   hits[3];
  bit   mmatch[3];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      win[d] = 0; valid[d] = 0; hits[d] = 0; mmatch[d] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit en, input bit din, input bit clr);
    for (int d = 0; d < 3; d++) begin
      if (clr) begin
        win[d] = 0; valid[d] = 0; hits[d] = 0; mmatch[d] = 1'b0;
      end else if (!en) begin
        mmatch[d] = 1'b0;
      end else begin
        win[d] = (win[d] * 2 + int'(din)) % 16;
        if (valid[d] < 4) valid[d]++;
        mmatch[d] = (win[d] == 11) && (valid[d] >= 4);
        if (mmatch[d]) begin
          hits[d]++;
          if (ovl[d] == 0) valid[d] = 0;
        end
      end
    end
  endfunction

  function automatic int sat(input int d);
    return (hits[d] > cmax[d]) ? cmax[d] : hits[d];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.m  = {mmatch[2], mmatch[1], mmatch[0]};
    e.c0 = 8'(sat(0));
    e.c1 = 2'(sat(1));
    e.c2 = 2'(sat(2));
    e.s0 = 4'(win[0]);
    e.s1 = 4'(win[1]);
    e.s2 = 4'(win[2]);
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    chk({tag, "_match0"}, int'(match[0]), int'(e.m[0]));
    chk({tag, "_match1"}, int'(match[1]), int'(e.m[1]));
    chk({tag, "_match2"}, int'(match[2]), int'(e.m[2]));
    chk({tag, "_count0"}, int'(count0), int'(e.c0));
    chk({tag, "_count1"}, int'(count1), int'(e.c1));
    chk({tag, "_count2"}, int'(count2), int'(e.c2));
    chk({tag, "_shift0"}, int'(shift0), int'(e.s0));
    chk({tag, "_shift1"}, int'(shift1), int'(e.s1));
    chk({tag, "_shift2"}, int'(shift2), int'(e.s2));
  endtask

  // Driver: inputs change at the falling edge, expectation pushed at the rising edge.
  task automatic step(input bit en, input bit din, input bit clr = 1'b0);
    bit clr_eff;
    Enable  = en;
    Din     = din;
`ifdef SEQ_DET_CLEAR_EN
    Clear   = clr;
    clr_eff = clr;
`else
    clr_eff = 1'b0;
`endif
    @(posedge Clock);
    if (!Resetn) model_reset();
    else         model_edge(en, din, clr_eff);
    sb.push_back(model_out());
    @(negedge Clock);
  endtask

  task automatic feed(input int bits, input int len);
    for (int i = len - 1; i >= 0; i--) step(1'b1, bit'((bits >> i) & 1));
  endtask

  // Reset pulse placed in the low phase, away from any rising edge.
  task automatic async_reset();
    #1 Resetn = 1'b0;
    #1 model_reset();
    compare_all("async_rst", model_out());
    #1 Resetn = 1'b1;
  endtask

  always @(negedge Clock) begin
    if (sb.size() > 0) compare_all("sb", sb.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge Clock);
    repeat (2) step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    Resetn = 1'b1;
    repeat (3) step(1'b0, bit'($urandom_range(0, 1)));

    feed(4'b1011, 4);
    feed(3'b011, 3);

    async_reset();
    feed(4'b1011, 4);
    repeat (5) feed(3'b011, 3);

    feed(3'b101, 3);
    async_reset();
    step(1'b1, 1'b1);

`ifdef SEQ_DET_CLEAR_EN
    async_reset();
    repeat (3) feed(4'b1011, 4);
    feed(3'b101, 3);
    step(1'b1, 1'b1, 1'b1);
    feed(4'b1011, 4);
`endif

    repeat (600) begin
      step($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) async_reset();
    end
    step(1'b0, 1'b0);

    @(negedge Clock);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Serial pattern detector that consumes the single-bit stream produced by the async-reset D flip-flop stage (its Q drives Din here).
- Shifts in one bit per enabled clock, compares the most recent N bits against a fixed PATTERN, pulses Match on a hit and keeps a saturating hit count.
- Optional overlap handling lets the same block serve both framed and free-running streams.

Parameters:
N, 4, pattern length in bits (2..16)
PATTERN, 4'b1011, N-bit target sequence; MSB is the oldest bit received
OVERLAP, 1, 1 = bits of a match may start the next match; 0 = window restarts empty after each match
CW, 8, width of the match counter

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
Enable  input  1  sample Din on this edge when 1; hold all state when 0
Din  input  1  serial data bit
Match  output  1  registered one-cycle hit pulse
Count  output  CW  saturating number of matches since reset
Shift  output  N  current window; Shift[0] is the newest bit

Behaviour:
- Reset (Resetn=0, asynchronous, no clock needed): Shift=0, Match=0, Count=0, fill counter=0, FSM=FILL. Reset asserted mid-stream discards all partial history immediately.
- FSM states:
  - FILL: fewer than N valid bits held.
  - HUNT: window full, comparing every enabled edge.
- Every rising edge with Enable=1: Shift <= {Shift[N-2:0], Din}.
- FILL: fill counter increments. Move to HUNT on the edge that captures the Nth valid bit.
- Hit condition, evaluated on the same edge: {Shift[N-2:0],Din}==PATTERN and (state==HUNT or fill counter==N-1).
- On a hit:
  - Match <= 1; it is high for exactly the one cycle following the edge that sampled the last pattern bit (latency 1 edge, no extra pipeline).
  - Count <= Count+1, unless Count is all-ones; then it holds at all-ones while Match still pulses.
  - OVERLAP=1: stay or go to HUNT; Shift keeps the new value.
  - OVERLAP=0: go to FILL with fill counter=0. Shift still loads the new value, but those bits are not eligible for a match until N fresh bits arrive.
- Enable=0 on an edge: Shift, fill counter, FSM and Count hold; Match <= 0. A pulse never stretches across disabled cycles.
- Match is 0 on every edge with no hit; back-to-back hits give back-to-back pulses (possible only with OVERLAP=1, e.g. all-ones PATTERN).
- Shift reflects raw history, including bits captured during FILL.
- All outputs are registered; no combinational path from Din to any output.

Optional Feature:
- Macro: SEQ_DET_CLEAR_EN
- Defined: adds input Clear (1 bit, synchronous, active-high). On an edge with Clear=1:
  - Count <= 0, Match <= 0, fill counter <= 0, FSM <= FILL, Shift <= 0.
  - Clear overrides Enable and any simultaneous hit; the hit is not counted.
  - Resetn still dominates Clear.
- Not defined: no Clear port; counters are cleared only by Resetn.

Test Plan:
- Resetn=0 held two cycles with random Din -> Match=0, Count=0, Shift=4'b0000 throughout. Release, then apply Enable=0 for 3 edges -> all outputs unchanged.
- OVERLAP=1, Enable=1, Din stream 1,0,1,1 -> Match=1 only in the cycle after edge 4, Shift=4'b1011, Count=1.
- OVERLAP=1, stream 1,0,1,1,0,1,1 -> Match pulses after edges 4 and 7, Count=2. Same stream with OVERLAP=0 -> single pulse after edge 4, Count=1.
- CW=2, OVERLAP=1, stream 1011 followed by 011 repeated 5 times (6 hits) -> six Match pulses, Count saturates at 2'b11 and stays there.
- Stream 1,0,1, then Resetn pulsed low between edges, then Din=1 on the next edge -> no Match, Count=0, Shift=4'b0001.
- SEQ_DET_CLEAR_EN defined: build Count=3, then assert Clear on the edge completing a fourth 1011 -> Match=0, Count=0, Shift=0. Next 1,0,1,1 -> Count=1.
